multi_key_debounce: RTL
=======================

MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent key channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_TIME, default 2000: consecutive stable cycles required to accept a change (20 ms at 100 kHz); legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16: debounce counter width per channel.
REQ-004 SHALL have parameter LONG_TIME, default 100000: cycles of continuous debounced press before the long-press pulse (1 s); legal range 1..2^LONG_W-1.
REQ-005 SHALL have parameter LONG_W, default 20: long-press counter width per channel.
REQ-006 SHALL have parameter ACTIVE_LOW, default 0: 1 means a pressed key drives key_in low.
REQ-007 SHALL have port clk_100kHz, input, 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port key_in, input, N_KEYS: raw asynchronous key levels.
REQ-010 SHALL have port key_out, output, N_KEYS: debounced pressed state, 1 = pressed, independent of ACTIVE_LOW.
REQ-011 SHALL have port key_press, output, N_KEYS: one-cycle pulse when key_out rises.
REQ-012 SHALL have port key_release, output, N_KEYS: one-cycle pulse when key_out falls.
REQ-013 SHALL have port key_long, output, N_KEYS: one-cycle pulse on reaching the long-press threshold.

Function
REQ-014 Each key_in bit SHALL pass through a 2-flop synchroniser; the polarity-corrected sample is p = sync ^ ACTIVE_LOW.
REQ-015 Channels SHALL be fully independent; no channel's activity changes another channel's timing or outputs.
REQ-016 Per channel: when p != key_out, cnt SHALL increment; when p == key_out, cnt SHALL clear to 0 in the same cycle, so any glitch restarts the count.
REQ-017 When p != key_out and cnt == DEBOUNCE_TIME-1, the next edge SHALL set key_out <= p and cnt <= 0; key_out changes after exactly DEBOUNCE_TIME consecutive disagreeing cycles.
REQ-018 Latency from a clean key_in edge to the key_out change SHALL be 2 + DEBOUNCE_TIME cycles.
REQ-019 cnt SHALL never exceed DEBOUNCE_TIME-1 and SHALL never wrap.
REQ-020 key_press (key_release) SHALL be registered and high for exactly one cycle, the first cycle in which key_out reads 1 (0) after the transition.
REQ-021 Long counter lcnt SHALL clear while key_out = 0 and increment while key_out = 1, saturating at LONG_TIME.
REQ-022 key_long SHALL pulse for one cycle, the cycle in which lcnt reaches LONG_TIME; it SHALL fire once per press, with no auto-repeat.
REQ-023 A release before LONG_TIME SHALL produce key_release and no key_long; a later press SHALL restart lcnt from 0.
REQ-024 key_press and key_long SHALL never be high together for the same channel; with LONG_TIME=1, key_long SHALL follow key_press by one cycle.
REQ-025 Simultaneous transitions on several channels in one cycle SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 rst_ low SHALL asynchronously force synchroniser flops to ACTIVE_LOW, and key_out, key_press, key_release, key_long, cnt and lcnt to 0.
REQ-027 Reset asserted mid-count or mid-press SHALL discard all state; after release, a key still held SHALL need the full 2 + DEBOUNCE_TIME cycles to re-assert key_out.
REQ-028 No output pulse SHALL be generated by reset assertion or deassertion.

Verification (bench params: N_KEYS=4, DEBOUNCE_TIME=4, LONG_TIME=10)
REQ-029 Clean press on key 0 held 20 cycles -> key_out[0]=1 exactly 6 cycles after the edge; key_press[0] one cycle; key_long[0] one cycle 10 cycles after key_out[0] rises.
REQ-030 Key 1 bounces 1,0,1,0 one cycle each, then stays 1 -> no key_out change during the bounce; key_out[1] rises 6 cycles after the final stable edge; one key_press only.
REQ-031 Key 2 pressed 8 cycles, then released -> key_press and key_release one pulse each, key_long never asserted.
REQ-032 Keys 0 and 3 pressed in the same cycle -> both key_out bits and both key_press bits assert in the same cycle.
REQ-033 rst_ pulsed low while key 0 is held, 3 cycles into debounce and again after key_out=1 -> all outputs 0 immediately with no pulses; key_out[0] re-asserts 6 cycles after rst_ returns high.
REQ-034 ACTIVE_LOW=1 with key_in idle high -> key_out=0 after reset; driving key_in[0] low -> key_out[0]=1 after 6 cycles.

Source files
------------

// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer: per-key 2-flop sync, stable-count debounce,
// registered press/release edge pulses and a one-shot long-press pulse.

module key_lane #(
  parameter int CNT_W         = 16,
  parameter int DEBOUNCE_TIME = 2000,
  parameter int LONG_W        = 20,
  parameter int LONG_TIME     = 100000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk_100kHz,
  input  logic rst_,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [LONG_W-1:0] LT      = LONG_W'(LONG_TIME);
  localparam logic              IDLE    = 1'(ACTIVE_LOW);

  logic [1:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [LONG_W-1:0] lcnt;
  logic              p, flip;

  assign p    = sync[1] ^ IDLE;
  assign flip = (p != key_out) && (cnt == DB_LAST);

  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      sync        <= {2{IDLE}};
      cnt         <= '0;
      lcnt        <= '0;
      key_out     <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      // any agreeing cycle restarts the count, so a glitch never accumulates
      if (p == key_out || flip) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
      if (flip) key_out <= p;
      key_press   <= flip & p;
      key_release <= flip & ~p;
      // saturating at LT makes the long pulse one-shot per press
      if (!key_out)       lcnt <= '0;
      else if (lcnt != LT) lcnt <= lcnt + 1'b1;
      key_long <= key_out && (lcnt == LT - 1'b1);
    end
  end
endmodule

module multi_key_debounce #(
  parameter int N_KEYS        = 4,
  parameter int DEBOUNCE_TIME = 2000,
  parameter int CNT_W         = 16,
  parameter int LONG_TIME     = 100000,
  parameter int LONG_W        = 20,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic              clk_100kHz,
  input  logic              rst_,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);
  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_lane #(
      .CNT_W(CNT_W), .DEBOUNCE_TIME(DEBOUNCE_TIME),
      .LONG_W(LONG_W), .LONG_TIME(LONG_TIME), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_lane (
      .clk_100kHz (clk_100kHz),
      .rst_       (rst_),
      .key_in     (key_in[g]),
      .key_out    (key_out[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end
endmodule
